// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one single-port memory between
// instruction fetch (port 0) and load/store (port 1). One transaction is
// in flight at a time: IDLE arbitrates, ACCESS drives the memory until it
// acks or the timeout expires, RESP returns a one-cycle ack to the winner.
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_rd_en_i,
   input  logic        p0_wr_en_i,
   input  logic [31:0] p0_addr_i,
   input  logic [31:0] p0_data_i,
   output logic [31:0] p0_data_o,
   output logic        p0_ack_o,
   input  logic        p1_rd_en_i,
   input  logic        p1_wr_en_i,
   input  logic [31:0] p1_addr_i,
   input  logic [31:0] p1_data_i,
   output logic [31:0] p1_data_o,
   output logic        p1_ack_o,
   output logic        mem_rd_en_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i,
   output logic        err_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   // Last counter value before a missing memory ack becomes an error.
   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;

   // Control registers (reset).
   logic        r_last_grant;
   logic [7:0]  r_cnt;
   logic        r_err;

   // Transaction registers (only meaningful once a grant has happened).
   logic        r_port;
   logic        r_wr;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;

   logic        w_p0_req;
   logic        w_p1_req;
   logic        w_grant;
   logic        w_grant_port;
   logic        w_timeout;
   logic        w_access;
   logic        w_resp;

   assign w_p0_req = p0_rd_en_i | p0_wr_en_i;
   assign w_p1_req = p1_rd_en_i | p1_wr_en_i;

   // Next-state logic: round-robin grant in IDLE, ack/timeout exit from ACCESS.
   always_comb begin
      w_next       = r_state;
      w_grant      = 1'b0;
      w_grant_port = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_p0_req && w_p1_req) begin
               w_grant      = 1'b1;
               w_grant_port = ~r_last_grant;
            end else if (w_p0_req) begin
               w_grant      = 1'b1;
               w_grant_port = 1'b0;
            end else if (w_p1_req) begin
               w_grant      = 1'b1;
               w_grant_port = 1'b1;
            end
            if (w_grant) begin
               w_next = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (mem_ack_i) begin
               w_next = S_RESP;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_timeout = 1'b1;
               w_next    = S_RESP;
            end
         end
         S_RESP: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State register plus latching of the granted request and its response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_cnt        <= 8'd0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_port  <= w_grant_port;
                  r_cnt   <= 8'd0;
                  r_err   <= 1'b0;
                  // A simultaneous rd+wr is treated as a write.
                  r_wr    <= w_grant_port ? p1_wr_en_i : p0_wr_en_i;
                  r_addr  <= w_grant_port ? p1_addr_i  : p0_addr_i;
                  r_wdata <= w_grant_port ? p1_data_i  : p0_data_i;
               end
            end
            S_ACCESS: begin
               if (mem_ack_i) begin
                  r_rdata      <= r_wr ? 32'd0 : mem_data_i;
                  r_err        <= 1'b0;
                  r_last_grant <= r_port;
               end else if (w_timeout) begin
                  r_rdata      <= 32'd0;
                  r_err        <= 1'b1;
                  r_last_grant <= r_port;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign w_access = (r_state == S_ACCESS);
   assign w_resp   = (r_state == S_RESP);

   assign mem_rd_en_o = w_access & ~r_wr;
   assign mem_wr_en_o = w_access &  r_wr;
   assign mem_addr_o  = w_access ? r_addr  : 32'd0;
   assign mem_data_o  = w_access ? r_wdata : 32'd0;

   assign p0_ack_o  = w_resp & ~r_port;
   assign p1_ack_o  = w_resp &  r_port;
   assign p0_data_o = (w_resp && !r_port) ? r_rdata : 32'd0;
   assign p1_data_o = (w_resp &&  r_port) ? r_rdata : 32'd0;
   assign err_o     = w_resp & r_err;
   assign busy_o    = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory with programmable ack stall
// sits on the memory side, and a transaction-level model predicts grant
// order, ack cycle, read data and error for every request round.
module tb_mem_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_rd_en_i, p0_wr_en_i, p1_rd_en_i, p1_wr_en_i;
   logic [31:0] p0_addr_i, p0_data_i, p1_addr_i, p1_data_i;
   logic [31:0] p0_data_o, p1_data_o;
   logic        p0_ack_o, p1_ack_o;
   logic        mem_rd_en_o, mem_wr_en_o;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic        mem_ack_i;
   logic        err_o, busy_o;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_rd_en_i(p0_rd_en_i), .p0_wr_en_i(p0_wr_en_i), .p0_addr_i(p0_addr_i),
      .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
      .p1_rd_en_i(p1_rd_en_i), .p1_wr_en_i(p1_wr_en_i), .p1_addr_i(p1_addr_i),
      .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
      .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .err_o(err_o), .busy_o(busy_o)
   );

   // Memory side: 256 words, ack withheld for `stall` cycles of each access.
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   logic        tb_init;
   int          stall;
   int          acc_cnt;
   int          wr_cycles;
   logic [31:0] last_wr_addr;

   function automatic logic [31:0] seed_val(int i);
      if (i == 4) return 32'hDEADBEEF;
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
   endfunction

   assign mem_ack_i  = (mem_rd_en_o | mem_wr_en_o) && (acc_cnt >= stall);
   assign mem_data_i = mem[mem_addr_o[9:2]];

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed_val(i);
         acc_cnt   <= 0;
         wr_cycles <= 0;
      end else begin
         if (mem_wr_en_o && mem_ack_i) mem[mem_addr_o[9:2]] <= mem_data_o;
         if (mem_wr_en_o) begin
            wr_cycles    <= wr_cycles + 1;
            last_wr_addr <= mem_addr_o;
         end
         if (mem_rd_en_o || mem_wr_en_o) acc_cnt <= acc_cnt + 1;
         else acc_cnt <= 0;
      end
   end

   int total = 0;
   int bad   = 0;
   int last_g;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      p0_rd_en_i = 0; p0_wr_en_i = 0; p0_addr_i = 0; p0_data_i = 0;
      p1_rd_en_i = 0; p1_wr_en_i = 0; p1_addr_i = 0; p1_data_i = 0;
   endtask

   // One round: the chosen ports request at the same edge and hold until acked.
   // op bit0 = rd_en, bit1 = wr_en.
   task automatic run_round(input bit r0, input bit r1,
                            input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] d1,
                            input int s);
      logic [1:0]  op [2];
      logic [31:0] a [2];
      logic [31:0] d [2];
      logic [31:0] xd [2];
      int          e [2];
      int          f, m, nmax, p, t;
      bit          er, wr;
      op[0] = r0 ? op0 : 2'b00; op[1] = r1 ? op1 : 2'b00;
      a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
      e[0] = -1; e[1] = -1; xd[0] = 0; xd[1] = 0;
      m  = (s < TO) ? s : TO - 1;
      er = (s >= TO);
      f  = (r0 && r1) ? ((last_g == 1) ? 0 : 1) : (r0 ? 0 : 1);
      // Serve the winner, then (under contention) the held loser.
      for (int k = 0; k < ((r0 && r1) ? 2 : 1); k++) begin
         p  = (k == 0) ? f : 1 - f;
         t  = (k == 0) ? 2 + m : e[f] + 3 + m;
         wr = op[p][1];
         e[p]  = t;
         xd[p] = (er || wr) ? 32'd0 : ref_mem[a[p][9:2]];
         if (wr && !er) ref_mem[a[p][9:2]] = d[p];
         last_g = p;
      end
      nmax = ((e[0] > e[1]) ? e[0] : e[1]) + 1;

      stall = s;
      @(posedge clk); #1;
      p0_rd_en_i = op[0][0]; p0_wr_en_i = op[0][1]; p0_addr_i = a0; p0_data_i = d0;
      p1_rd_en_i = op[1][0]; p1_wr_en_i = op[1][1]; p1_addr_i = a1; p1_data_i = d1;
      for (int n = 1; n <= nmax; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            check_val("acc_rd", mem_rd_en_o, !op[f][1]);
            check_val("acc_wr", mem_wr_en_o, op[f][1]);
            check_val("acc_addr", mem_addr_o, a[f]);
            check_val("acc_wdata", mem_data_o, d[f]);
            check_val("acc_busy", busy_o, 1);
         end
         check_val("p0_ack", p0_ack_o, n == e[0]);
         check_val("p1_ack", p1_ack_o, n == e[1]);
         check_val("err", err_o, (n == e[0] || n == e[1]) ? er : 1'b0);
         check_val("p0_data", p0_data_o, (n == e[0]) ? xd[0] : 32'd0);
         check_val("p1_data", p1_data_o, (n == e[1]) ? xd[1] : 32'd0);
         if (p0_ack_o) begin p0_rd_en_i = 0; p0_wr_en_i = 0; end
         if (p1_ack_o) begin p1_rd_en_i = 0; p1_wr_en_i = 0; end
      end
      drive_idle();
      @(posedge clk); #1;
      check_val("idle_busy", busy_o, 0);
   endtask

   initial begin
      int          wc;
      logic [31:0] ra0, ra1;
      bit          q0, q1;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i);
      drive_idle();
      stall   = 0;
      rst_n   = 0;
      tb_init = 1;
      last_g  = 1;
      repeat (3) @(posedge clk);
      #1;
      tb_init = 0;
      check_val("rst_busy", busy_o, 0);
      check_val("rst_ack", {p0_ack_o, p1_ack_o, err_o, mem_rd_en_o, mem_wr_en_o}, 0);
      rst_n = 1;
      @(posedge clk); #1;

      // Port 0 read of word 4.
      run_round(1, 0, 2'b01, 32'h10, 32'h0, 2'b00, 32'h0, 32'h0, 0);

      // Port 1 write, exactly one write cycle to 0x20, then read it back.
      wc = wr_cycles;
      run_round(0, 1, 2'b00, 32'h0, 32'h0, 2'b10, 32'h20, 32'hCAFEF00D, 0);
      check_val("wr_cycles", 32'(wr_cycles - wc), 1);
      check_val("wr_addr", last_wr_addr, 32'h20);
      run_round(1, 0, 2'b01, 32'h20, 32'h0, 2'b00, 32'h0, 32'h0, 0);

      // Contention: four rounds of simultaneous reads.
      for (int i = 0; i < 4; i++)
         run_round(1, 1, 2'b01, 32'h40 + 32'(8 * i), 32'h0, 2'b01, 32'h44 + 32'(8 * i), 32'h0, 0);

      // Timeout on port 1, then a clean transaction.
      run_round(0, 1, 2'b00, 32'h0, 32'h0, 2'b01, 32'h30, 32'h0, 100);
      run_round(1, 0, 2'b01, 32'h34, 32'h0, 2'b00, 32'h0, 32'h0, 0);

      // Reset during ACCESS abandons the read.
      stall = 0;
      @(posedge clk); #1;
      p0_rd_en_i = 1; p0_addr_i = 32'h50;
      @(posedge clk); #1;
      check_val("pre_rst_acc", mem_rd_en_o, 1);
      rst_n = 0;
      @(posedge clk); #1;
      check_val("rst_mid_ack", {p0_ack_o, p1_ack_o, err_o}, 0);
      check_val("rst_mid_mem", {mem_rd_en_o, mem_wr_en_o, busy_o}, 0);
      check_val("rst_mid_addr", mem_addr_o, 0);
      drive_idle();
      rst_n  = 1;
      last_g = 1;
      run_round(1, 0, 2'b01, 32'h50, 32'h0, 2'b00, 32'h0, 32'h0, 0);

      // rd+wr together is a write returning 0; read back afterwards.
      run_round(1, 0, 2'b11, 32'h8, 32'h12345678, 2'b00, 32'h0, 32'h0, 0);
      run_round(1, 0, 2'b01, 32'h8, 32'h0, 2'b00, 32'h0, 32'h0, 0);
      run_round(1, 1, 2'b01, 32'h60, 32'h0, 2'b01, 32'h64, 32'h0, 0);

      // Randomized rounds.
      for (int i = 0; i < 60; i++) begin
         wc  = $urandom_range(1, 3);
         q0  = wc[0];
         q1  = wc[1];
         ra0 = $urandom & 32'h3FC;
         ra1 = ($urandom_range(0, 3) == 0) ? ra0 : ($urandom & 32'h3FC);
         run_round(q0, q1, 2'($urandom_range(1, 3)), ra0, $urandom,
                   2'($urandom_range(1, 3)), ra1, $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port `Memory` instance between the instruction-fetch requester (port 0) and the load/store requester (port 1). It accepts requests with a hold-until-ack handshake and arbitrates round-robin when both ports contend. It issues one memory transaction at a time, registers the read data, and returns a one-cycle acknowledge to the winning port. It sits between the CPU front-end/LSU and the `Memory` block and drives that block's `rd_en_i`/`wr_en_i`/`addr_i`/`data_i`.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in ACCESS waiting for `mem_ack_i` before forcing an error response; legal range 2–255.
- `clk` in 1: single clock; everything is posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `p0_rd_en_i`, `p0_wr_en_i` in 1 each: port 0 read/write request.
- `p0_addr_i`, `p0_data_i` in 32 each: port 0 byte address / write data.
- `p0_data_o` out 32: port 0 read data, valid only while `p0_ack_o`=1.
- `p0_ack_o` out 1: port 0 transaction complete, one-cycle pulse.
- `p1_*`: same six signals for port 1.
- `mem_rd_en_o`, `mem_wr_en_o` out 1 each: to Memory `rd_en_i`/`wr_en_i`.
- `mem_addr_o`, `mem_data_o` out 32 each: to Memory `addr_i`/`data_i`.
- `mem_data_i` in 32, `mem_ack_i` in 1: from Memory `data_o`/`ack_o`.
- `err_o` out 1: pulses together with an ack that ended by timeout.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- Requester protocol:
  - A request is `rd_en` or `wr_en` high. The requester holds `en`, `addr` and `data` stable until it sees its ack.
  - The requester must deassert in the cycle after the ack, or it issues a new request.
  - If `rd_en` and `wr_en` are both high, the request is a write and the returned data is 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitration uses the live requests.
  - If exactly one port requests, that port is granted.
  - If both request, the grant goes to the port not served last, tracked by `last_grant`.
  - On grant: latch port id, op, addr and wdata into internal registers; clear the timeout counter; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Drive `mem_addr_o`/`mem_data_o` from the latched registers.
  - Assert exactly one of `mem_rd_en_o`/`mem_wr_en_o` per the latched op.
  - If `mem_ack_i`=1: capture `mem_data_i` into the response register (reads; writes capture 0), update `last_grant`, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT-1` without ack: set the response register to 0, set the error flag, update `last_grant`, go to RESP.
- RESP:
  - Assert the granted port's ack for exactly one cycle, with its data from the response register.
  - `err_o` equals the error flag.
  - Go to IDLE.
- Outside RESP: both `pN_ack_o`=0, both `pN_data_o`=0, `err_o`=0.
- Outside ACCESS: `mem_rd_en_o`=`mem_wr_en_o`=0, `mem_addr_o`=`mem_data_o`=0.
- Changes to requester inputs after grant are ignored; the latched values are used.
- Reset (`rst_n`=0 at a clk edge):
  - State IDLE, all outputs 0, `last_grant`=1 so port 0 wins the first contention, counter 0, error flag 0.
  - Reset mid-ACCESS or mid-RESP abandons the transaction with no ack.
  - A write whose ACCESS edge coincides with reset may or may not land in memory.

## Timing
- Request first high at edge T (sampled in IDLE) → ACCESS during T+1 → ack during T+2 when `mem_ack_i` is high in the first ACCESS cycle, which is always true for `Memory`.
- Best-case latency is 2 cycles; throughput is one transaction per 3 cycles.
- A write reaches memory at the edge ending the first ACCESS cycle.
- Read data is captured at the same edge from the combinational `mem_data_i`.
- Each extra cycle of `mem_ack_i`=0 adds one cycle of latency, up to TIMEOUT cycles in ACCESS.
- Under continuous contention, grants alternate 0,1,0,1…; worst-case wait for a port is one foreign transaction (3 cycles) plus its own.

## Test plan
- Port 0 read of 0x10 (mem word 4 = 0xDEADBEEF) after reset → `p0_ack_o` pulses 2 cycles after the request, `p0_data_o`=0xDEADBEEF, `p1_ack_o`=0, `err_o`=0.
- Port 1 write 0xCAFEF00D to 0x20, then port 0 read 0x20 → exactly one `mem_wr_en_o` cycle with addr 0x20; the read returns 0xCAFEF00D.
- Both ports request reads on the same cycle, held and re-issued for 4 transactions each → ack order 0,1,0,1,…; each ack returns its own address's data.
- `mem_ack_i` tied 0, `TIMEOUT`=4, port 1 read → ACCESS lasts 4 cycles, then `p1_ack_o`=1 with `err_o`=1 and `p1_data_o`=0; the next transaction has `err_o`=0.
- `rst_n` low during ACCESS of a port 0 read → no ack issued; all outputs 0 the cycle after; a re-issued request completes normally in 2 cycles.
- Port 0 asserts `rd_en` and `wr_en` together with data 0x12345678 to 0x8 → `mem_wr_en_o`=1, `mem_rd_en_o`=0, ack with `p0_data_o`=0; a later read of 0x8 returns 0x12345678.
